// File: rtl/vga_playback_ctrl_if.sv
// Control/status bundle between the video player's command source and the frame sequencer.
// The slave side is the sequencer; the master side drives vsync, commands and settings.
interface vga_playback_ctrl_if #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned CNT_W  = 7
) ();

  logic              vs;
  logic              cmd_play;
  logic              cmd_pause;
  logic              cmd_step_fwd;
  logic              cmd_step_back;
  logic              loop_en;
  logic [CNT_W-1:0]  speed;
  logic [IDX_W-1:0]  frame_idx;
  logic [ADDR_W-1:0] frame_base_addr;
  logic              playing;
  logic              done;
  logic              frame_tick;

  modport master (
    output vs,
    output cmd_play,
    output cmd_pause,
    output cmd_step_fwd,
    output cmd_step_back,
    output loop_en,
    output speed,
    input  frame_idx,
    input  frame_base_addr,
    input  playing,
    input  done,
    input  frame_tick
  );

  modport slave (
    input  vs,
    input  cmd_play,
    input  cmd_pause,
    input  cmd_step_fwd,
    input  cmd_step_back,
    input  loop_en,
    input  speed,
    output frame_idx,
    output frame_base_addr,
    output playing,
    output done,
    output frame_tick
  );

endinterface

// File: rtl/vga_playback_ctrl.sv
// Frame sequencer: owns the displayed image index and its VRAM base address, and applies
// play/pause/step/loop/speed changes only at a vsync falling edge so the picture never tears.
module vga_playback_ctrl #(
  parameter int unsigned FRAME_COUNT = 5,
  parameter int unsigned FRAME_SIZE  = 30000,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned CNT_W       = 7
) (
  input  logic                pclk,
  input  logic                rst,
  vga_playback_ctrl_if.slave  ctrl_io
);

  localparam logic [IDX_W-1:0]  LastIdx   = IDX_W'(FRAME_COUNT - 1);
  localparam logic [ADDR_W-1:0] FrameSize = ADDR_W'(FRAME_SIZE);
  localparam logic [ADDR_W-1:0] LastBase  = ADDR_W'((FRAME_COUNT - 1) * FRAME_SIZE);

  typedef enum logic [1:0] {StStop, StPlay, StPause, StDone} state_e;
  typedef enum logic [2:0] {CmdNone, CmdPause, CmdPlay, CmdBack, CmdFwd} cmd_e;

  state_e            state_q;
  logic              vs_q;
  logic              fall_q;
  logic              pend_play_q;
  logic              pend_pause_q;
  logic              pend_fwd_q;
  logic              pend_back_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] base_q;
  logic              playing_q;
  logic              done_q;
  logic              tick_q;

  logic              vs_fall;
  cmd_e              cmd_sel;
  logic [CNT_W-1:0]  spd_m1;
  logic              cnt_hit;
  logic [IDX_W-1:0]  fwd_idx;
  logic [ADDR_W-1:0] fwd_base;
  logic [IDX_W-1:0]  back_idx;
  logic [ADDR_W-1:0] back_base;

  assign vs_fall = vs_q & ~ctrl_io.vs;

  // Highest-priority pending command; the rest are dropped at the same boundary.
  always_comb begin
    cmd_sel = CmdNone;
    if (pend_pause_q) begin
      cmd_sel = CmdPause;
    end else if (pend_play_q) begin
      cmd_sel = CmdPlay;
    end else if (pend_back_q) begin
      cmd_sel = CmdBack;
    end else if (pend_fwd_q) begin
      cmd_sel = CmdFwd;
    end
  end

  // Speed 0 behaves as 1; >= lets a speed decrease take effect at the next boundary.
  always_comb begin
    spd_m1  = (ctrl_io.speed == '0) ? '0 : ctrl_io.speed - 1'b1;
    cnt_hit = (cnt_q >= spd_m1);
  end

  // Neighbouring images with wrap; base address follows incrementally, no multiplier.
  always_comb begin
    if (idx_q == LastIdx) begin
      fwd_idx  = '0;
      fwd_base = '0;
    end else begin
      fwd_idx  = idx_q + 1'b1;
      fwd_base = base_q + FrameSize;
    end
    if (idx_q == '0) begin
      back_idx  = LastIdx;
      back_base = LastBase;
    end else begin
      back_idx  = idx_q - 1'b1;
      back_base = base_q - FrameSize;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q      <= StStop;
      vs_q         <= 1'b0;
      fall_q       <= 1'b0;
      pend_play_q  <= 1'b0;
      pend_pause_q <= 1'b0;
      pend_fwd_q   <= 1'b0;
      pend_back_q  <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      base_q       <= '0;
      playing_q    <= 1'b0;
      done_q       <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      vs_q   <= ctrl_io.vs;
      fall_q <= vs_fall;
      tick_q <= 1'b0;
      if (fall_q) begin
        // A pulse arriving while the boundary is being applied belongs to the next one.
        pend_play_q  <= ctrl_io.cmd_play;
        pend_pause_q <= ctrl_io.cmd_pause;
        pend_fwd_q   <= ctrl_io.cmd_step_fwd;
        pend_back_q  <= ctrl_io.cmd_step_back;
        case (state_q)
          StStop: begin
            if (cmd_sel == CmdPlay) begin
              state_q   <= StPlay;
              playing_q <= 1'b1;
              cnt_q     <= '0;
            end else if (cmd_sel == CmdBack) begin
              state_q <= StPause;
              idx_q   <= back_idx;
              base_q  <= back_base;
              tick_q  <= 1'b1;
            end else if (cmd_sel == CmdFwd) begin
              state_q <= StPause;
              idx_q   <= fwd_idx;
              base_q  <= fwd_base;
              tick_q  <= 1'b1;
            end
          end
          StPlay: begin
            if (cmd_sel == CmdPause) begin
              state_q   <= StPause;
              playing_q <= 1'b0;
              cnt_q     <= '0;
            end else if (cnt_hit) begin
              cnt_q <= '0;
              if ((idx_q != LastIdx) || ctrl_io.loop_en) begin
                idx_q  <= fwd_idx;
                base_q <= fwd_base;
                tick_q <= 1'b1;
              end else begin
                state_q   <= StDone;
                playing_q <= 1'b0;
                done_q    <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StPause: begin
            if (cmd_sel == CmdPlay) begin
              state_q   <= StPlay;
              playing_q <= 1'b1;
              cnt_q     <= '0;
            end else if (cmd_sel == CmdBack) begin
              idx_q  <= back_idx;
              base_q <= back_base;
              tick_q <= 1'b1;
            end else if (cmd_sel == CmdFwd) begin
              idx_q  <= fwd_idx;
              base_q <= fwd_base;
              tick_q <= 1'b1;
            end
          end
          StDone: begin
            // Index sits at the last image here, so fwd lands on 0 and back on last-1.
            if (cmd_sel == CmdPlay) begin
              state_q   <= StPlay;
              playing_q <= 1'b1;
              done_q    <= 1'b0;
              cnt_q     <= '0;
              idx_q     <= fwd_idx;
              base_q    <= fwd_base;
              tick_q    <= 1'b1;
            end else if (cmd_sel == CmdBack) begin
              state_q <= StPause;
              done_q  <= 1'b0;
              idx_q   <= back_idx;
              base_q  <= back_base;
              tick_q  <= 1'b1;
            end else if (cmd_sel == CmdFwd) begin
              state_q <= StPause;
              done_q  <= 1'b0;
              idx_q   <= fwd_idx;
              base_q  <= fwd_base;
              tick_q  <= 1'b1;
            end
          end
          default: begin
            state_q   <= StStop;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
          end
        endcase
      end else begin
        pend_play_q  <= pend_play_q  | ctrl_io.cmd_play;
        pend_pause_q <= pend_pause_q | ctrl_io.cmd_pause;
        pend_fwd_q   <= pend_fwd_q   | ctrl_io.cmd_step_fwd;
        pend_back_q  <= pend_back_q  | ctrl_io.cmd_step_back;
      end
    end
  end

  assign ctrl_io.frame_idx       = idx_q;
  assign ctrl_io.frame_base_addr = base_q;
  assign ctrl_io.playing         = playing_q;
  assign ctrl_io.done            = done_q;
  assign ctrl_io.frame_tick      = tick_q;

endmodule

// File: tb/tb_vga_playback_ctrl.sv
// Directed bench for vga_playback_ctrl: expected frame changes are queued as stimulus is issued
// and a monitor pops one entry per frame_tick; level checks cover reset, DONE and no-change cases.
module tb_vga_playback_ctrl;

  localparam int unsigned FC = 5;
  localparam int unsigned FS = 30000;
  localparam int unsigned AW = 18;
  localparam int unsigned IW = 4;
  localparam int unsigned CW = 7;

  localparam int CmdNone  = 0;
  localparam int CmdPlay  = 1;
  localparam int CmdPause = 2;
  localparam int CmdFwd   = 3;
  localparam int CmdBack  = 4;

  logic pclk = 1'b0;
  logic rst;

  always #5 pclk = ~pclk;

  vga_playback_ctrl_if #(.IDX_W(IW), .ADDR_W(AW), .CNT_W(CW)) bus ();

  vga_playback_ctrl #(
    .FRAME_COUNT(FC),
    .FRAME_SIZE (FS),
    .ADDR_W     (AW),
    .IDX_W      (IW),
    .CNT_W      (CW)
  ) dut (
    .pclk   (pclk),
    .rst    (rst),
    .ctrl_io(bus)
  );

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [AW-1:0] base;
    logic          playing;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int idx, input int playing, input int done);
    check({name, ".idx"}, 32'(bus.frame_idx), idx);
    check({name, ".base"}, 32'(bus.frame_base_addr), idx * FS);
    check({name, ".playing"}, 32'(bus.playing), playing);
    check({name, ".done"}, 32'(bus.done), done);
  endtask

  task automatic push(input int idx, input int playing, input int done);
    exp_t e;
    e.idx     = IW'(idx);
    e.base    = AW'(idx * FS);
    e.playing = playing[0];
    e.done    = done[0];
    exp_q.push_back(e);
  endtask

  task automatic set_cmd(input int c, input logic v);
    case (c)
      CmdPlay:  bus.cmd_play      = v;
      CmdPause: bus.cmd_pause     = v;
      CmdFwd:   bus.cmd_step_fwd  = v;
      CmdBack:  bus.cmd_step_back = v;
      default:  ;
    endcase
  endtask

  task automatic pulse(input int c);
    @(posedge pclk); #1 set_cmd(c, 1'b1);
    @(posedge pclk); #1 set_cmd(c, 1'b0);
  endtask

  // One vsync low pulse; c optionally pulses a command on the falling-edge cycle itself.
  task automatic frame(input int c = CmdNone);
    @(posedge pclk); #1 bus.vs = 1'b0; set_cmd(c, 1'b1);
    @(posedge pclk); #1 set_cmd(c, 1'b0);
    @(posedge pclk); #1 bus.vs = 1'b1;
    repeat (5) @(posedge pclk);
    #1;
  endtask

  // Scoreboard monitor: every frame_tick must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (rst === 1'b0 && bus.frame_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tick_unexpected: got tick at idx=%0d base=%0d, expected no tick",
                   bus.frame_idx, bus.frame_base_addr);
        end else begin
          e = exp_q.pop_front();
          if (bus.frame_idx !== e.idx || bus.frame_base_addr !== e.base ||
              bus.playing !== e.playing || bus.done !== e.done) begin
            errors++;
            $display("FAIL tick_frame: got idx=%0d base=%0d playing=%0d done=%0d expected idx=%0d base=%0d playing=%0d done=%0d",
                     bus.frame_idx, bus.frame_base_addr, bus.playing, bus.done,
                     e.idx, e.base, e.playing, e.done);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.vs            = 1'b1;
    bus.cmd_play      = 1'b0;
    bus.cmd_pause     = 1'b0;
    bus.cmd_step_fwd  = 1'b0;
    bus.cmd_step_back = 1'b0;
    bus.loop_en       = 1'b1;
    bus.speed         = 7'd4;
    rst               = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    chk_out("reset", 0, 0, 0);
    check("reset.tick", 32'(bus.frame_tick), 0);
    rst = 1'b0;
    frame();
    chk_out("idle_after_reset", 0, 0, 0);

    // Looping playback at 4 vsyncs per image.
    pulse(CmdPlay);
    frame();
    chk_out("play_start", 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      push(k % FC, 1, 0);
      repeat (4) frame();
    end

    // One-shot playback ends in DONE on the last image; play restarts from 0.
    bus.loop_en = 1'b0;
    bus.speed   = 7'd1;
    for (int k = 1; k <= 4; k++) begin
      push(k, 1, 0);
      frame();
    end
    frame();
    chk_out("done", 4, 0, 1);
    pulse(CmdPlay);
    push(0, 1, 0);
    frame();

    // Pause and step with wrap; nothing moves before the boundary.
    pulse(CmdPause);
    chk_out("pause_pending", 0, 1, 0);
    frame();
    chk_out("paused", 0, 0, 0);
    pulse(CmdBack);
    chk_out("back_pending", 0, 0, 0);
    push(4, 0, 0);
    frame();
    pulse(CmdFwd);
    chk_out("fwd_pending", 4, 0, 0);
    push(0, 0, 0);
    frame();

    // pause beats play in the same frame, and losers are not carried over.
    pulse(CmdPlay);
    frame();
    chk_out("resume", 0, 1, 0);
    pulse(CmdPause);
    pulse(CmdPlay);
    frame();
    chk_out("pause_wins", 0, 0, 0);
    frame();
    chk_out("pending_cleared", 0, 0, 0);
    push(1, 0, 0);
    frame(CmdFwd);
    chk_out("cmd_on_fall", 1, 0, 0);

    // speed 0 acts as 1; a speed drop below cnt+1 advances at the next boundary.
    pulse(CmdPlay);
    frame();
    bus.speed   = 7'd0;
    bus.loop_en = 1'b1;
    push(2, 1, 0);
    frame();
    push(3, 1, 0);
    frame();
    bus.speed = 7'd8;
    repeat (5) frame();
    chk_out("speed8_hold", 3, 1, 0);
    bus.speed = 7'd2;
    push(4, 1, 0);
    frame();
    bus.speed = 7'd1;
    for (int k = 0; k <= 3; k++) begin
      push(k, 1, 0);
      frame();
    end

    // Asynchronous reset mid-play at idx 3, with a command pending.
    pulse(CmdFwd);
    @(posedge pclk); #1 rst = 1'b1;
    #1;
    chk_out("async_reset", 0, 0, 0);
    check("async_reset.tick", 32'(bus.frame_tick), 0);
    repeat (2) @(posedge pclk);
    #1 rst = 1'b0;
    repeat (2) frame();
    chk_out("post_reset_idle", 0, 0, 0);
    pulse(CmdPlay);
    frame();
    chk_out("post_reset_play", 0, 1, 0);
    push(1, 1, 0);
    frame();
    repeat (3) @(posedge pclk);

    check("ticks_outstanding", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
